// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES subkey generator (K1..K16 or K16..K1) over valid/ready; ports clk, rst, load, key_in, decrypt, subkey_ready -> subkey, subkey_valid, round, busy, done
module des_key_schedule #(
  parameter bit AUTO_ADVANCE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);
  typedef enum logic {IDLE, GEN} state_t;
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  function automatic logic [55:0] pc1(input logic [63:0] k);
    for (int j = 0; j < 56; j++) pc1[55-j] = k[64-PC1[j]];
  endfunction
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    for (int j = 0; j < 48; j++) pc2[47-j] = cd[56-PC2[j]];
  endfunction
  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    rotl = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction
  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    rotr = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction
  state_t      state_q;
  logic [27:0] c_q, d_q, c_d, d_d;
  logic [47:0] subkey_q;
  logic [3:0]  round_q;
  logic        dec_q, valid_q, done_q, accept, last, two;
  // Stepping from round index r into r+1 shifts by one only when r is 0, 7 or 14,
  // which covers both directions since decrypt mirrors the encrypt shift table.
  assign two    = !(round_q == 4'd0 || round_q == 4'd7 || round_q == 4'd14);
  assign accept = state_q == GEN && valid_q && (AUTO_ADVANCE || subkey_ready);
  assign last   = round_q == 4'd15;
  // First cycle of GEN primes C,D: encrypt shifts once into round 1, decrypt
  // starts from C0,D0 which equals C16,D16.
  always_comb begin
    c_d = !valid_q ? (dec_q ? c_q : rotl(c_q, 1'b0)) : (dec_q ? rotr(c_q, two) : rotl(c_q, two));
    d_d = !valid_q ? (dec_q ? d_q : rotl(d_q, 1'b0)) : (dec_q ? rotr(d_q, two) : rotl(d_q, two));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      c_q      <= '0;
      d_q      <= '0;
      dec_q    <= 1'b0;
      subkey_q <= '0;
      valid_q  <= 1'b0;
      round_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        state_q    <= GEN;
        {c_q, d_q} <= pc1(key_in);
        dec_q      <= decrypt;
        valid_q    <= 1'b0;
        round_q    <= '0;
      end else if (state_q == GEN && !valid_q) begin
        c_q      <= c_d;
        d_q      <= d_d;
        subkey_q <= pc2({c_d, d_d});
        valid_q  <= 1'b1;
      end else if (accept && !last) begin
        c_q      <= c_d;
        d_q      <= d_d;
        subkey_q <= pc2({c_d, d_d});
        round_q  <= round_q + 4'd1;
      end else if (accept) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        round_q <= '0;
        done_q  <= 1'b1;
      end
    end
  end
  assign subkey       = subkey_q;
  assign subkey_valid = valid_q;
  assign round        = round_q;
  assign busy         = state_q == GEN;
  assign done         = done_q;
endmodule
